// File: rtl/fnd_scan_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : fnd_scan_ctrl_if
//  Description : Load/status bundle between the time/counter datapath and the
//                FND scan controller.
//                  load       - single-cycle capture strobe (datapath -> ctrl)
//                  bcd_in     - packed codes, digit k at [4k+3:4k]
//                  dp_mask    - per-digit decimal point enable
//                  blink_mask - per-digit blink enable
//                  busy       - staged data waiting for frame boundary
//                  frame_done - one-cycle pulse at each frame boundary
//  Revision    : 1.0 - initial release
// ============================================================================
interface fnd_scan_ctrl_if #(
    parameter int DIGITS = 4
);
    logic                  load;
    logic [4*DIGITS-1:0]   bcd_in;
    logic [DIGITS-1:0]     dp_mask;
    logic [DIGITS-1:0]     blink_mask;
    logic                  busy;
    logic                  frame_done;

    // Datapath side
    modport master (
        output load, bcd_in, dp_mask, blink_mask,
        input  busy, frame_done
    );

    // Scan controller side
    modport slave (
        input  load, bcd_in, dp_mask, blink_mask,
        output busy, frame_done
    );
endinterface
`default_nettype wire

// File: rtl/fnd_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : fnd_scan_ctrl
//  Description : N-digit multiplexed 7-segment scan controller with on-board
//                refresh prescaler, frame-synchronous double-buffered data,
//                per-digit DP and blink masks.
//                Optional leading-zero blanking: define FND_LZ_BLANK_EN.
//  Ports       : clk      - system clock
//                rst_n    - asynchronous active-low reset
//                bus      - fnd_scan_ctrl_if.slave (load/data/masks/status)
//                an       - active-low anode select, one-hot-low
//                seg_out  - active-low segments {dp,g,f,e,d,c,b,a}
//  Revision    : 1.0 - initial release
// ============================================================================
module fnd_scan_ctrl #(
    parameter int DIGITS       = 4,
    parameter int SCAN_DIV     = 100_000,
    parameter int BLINK_FRAMES = 125
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    fnd_scan_ctrl_if.slave         bus,
    output logic [DIGITS-1:0]      an,
    output logic [7:0]             seg_out
);

    localparam int IDX_W = $clog2(DIGITS);
    localparam int PRE_W = $clog2(SCAN_DIV);
    localparam int FRM_W = $clog2(BLINK_FRAMES + 1);

    localparam logic [PRE_W-1:0] C_PRE_LAST = PRE_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] C_IDX_LAST = IDX_W'(DIGITS - 1);
    localparam logic [FRM_W-1:0] C_FRM_LAST = FRM_W'(BLINK_FRAMES - 1);

    // 7-segment pattern for bits 6:0, active low
    function automatic logic [6:0] enc7(input logic [3:0] code);
        logic [6:0] seg;
        case (code)
            4'h0:    seg = 7'h40;
            4'h1:    seg = 7'h79;
            4'h2:    seg = 7'h24;
            4'h3:    seg = 7'h30;
            4'h4:    seg = 7'h19;
            4'h5:    seg = 7'h12;
            4'h6:    seg = 7'h02;
            4'h7:    seg = 7'h78;
            4'h8:    seg = 7'h00;
            4'h9:    seg = 7'h10;
            4'hA:    seg = 7'h3F;   // minus sign
            default: seg = 7'h7F;   // blank
        endcase
        return seg;
    endfunction

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [PRE_W-1:0]    r_pre;
    // r_idx is the digit that will be driven at the next tick
    logic [IDX_W-1:0]    r_idx;
    logic [4*DIGITS-1:0] r_stg_bcd;
    logic [DIGITS-1:0]   r_stg_dp;
    logic [DIGITS-1:0]   r_stg_bl;
    logic [4*DIGITS-1:0] r_shd_bcd;
    logic [DIGITS-1:0]   r_shd_dp;
    logic [DIGITS-1:0]   r_shd_bl;
    logic                r_busy;
    logic                r_frame_done;
    logic [FRM_W-1:0]    r_frm;
    logic                r_hidden;

    // ------------------------------------------------------------------
    // Combinational
    // ------------------------------------------------------------------
    logic                w_tick;
    logic                w_boundary;
    logic                w_frm_wrap;
    logic                w_hidden_nxt;
    logic [4*DIGITS-1:0] w_shd_nxt_bcd;
    logic [DIGITS-1:0]   w_shd_nxt_dp;
    logic [DIGITS-1:0]   w_shd_nxt_bl;
    // Data the selected digit is encoded from: at a boundary this is the
    // incoming frame, so digit 0 of the new frame already shows new data.
    logic [4*DIGITS-1:0] w_src_bcd;
    logic [DIGITS-1:0]   w_src_dp;
    logic [DIGITS-1:0]   w_src_bl;
    logic                w_src_hidden;
    logic [3:0]          w_code_arr [DIGITS];
    logic [DIGITS-1:0]   w_lz;
    logic [7:0]          w_seg;

    always_comb begin
        w_tick        = (r_pre == C_PRE_LAST);
        w_boundary    = w_tick && (r_idx == '0);
        w_frm_wrap    = (r_frm == C_FRM_LAST);
        w_hidden_nxt  = r_hidden ^ w_frm_wrap;

        // A load coinciding with the boundary bypasses staging
        w_shd_nxt_bcd = bus.load ? bus.bcd_in     : r_stg_bcd;
        w_shd_nxt_dp  = bus.load ? bus.dp_mask    : r_stg_dp;
        w_shd_nxt_bl  = bus.load ? bus.blink_mask : r_stg_bl;

        w_src_bcd     = w_boundary ? w_shd_nxt_bcd : r_shd_bcd;
        w_src_dp      = w_boundary ? w_shd_nxt_dp  : r_shd_dp;
        w_src_bl      = w_boundary ? w_shd_nxt_bl  : r_shd_bl;
        w_src_hidden  = w_boundary ? w_hidden_nxt  : r_hidden;
    end

    for (genvar k = 0; k < DIGITS; k++) begin : g_unpack
        assign w_code_arr[k] = w_src_bcd[4*k +: 4];
    end

`ifdef FND_LZ_BLANK_EN
    // Digit k (k>0) is a leading zero when it and every digit above it are 0
    for (genvar k = 0; k < DIGITS; k++) begin : g_lz
        if (k == 0) begin : g_lsd
            assign w_lz[k] = 1'b0;
        end else begin : g_upper
            assign w_lz[k] = (w_src_bcd[4*DIGITS-1:4*k] == '0);
        end
    end
`else
    assign w_lz = '0;
`endif

    always_comb begin
        w_seg = 8'hFF;
        if (!(w_src_hidden && w_src_bl[r_idx])) begin
            w_seg[7]   = ~w_src_dp[r_idx];
            w_seg[6:0] = w_lz[r_idx] ? 7'h7F : enc7(w_code_arr[r_idx]);
        end
    end

    // ------------------------------------------------------------------
    // Sequential
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pre        <= '0;
            r_idx        <= '0;
            r_stg_bcd    <= '1;
            r_stg_dp     <= '0;
            r_stg_bl     <= '0;
            r_shd_bcd    <= '1;
            r_shd_dp     <= '0;
            r_shd_bl     <= '0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
            r_frm        <= '0;
            r_hidden     <= 1'b0;
            an           <= '1;
            seg_out      <= 8'hFF;
        end else begin
            r_pre        <= w_tick ? '0 : r_pre + 1'b1;
            r_frame_done <= w_boundary;

            if (bus.load) begin
                r_stg_bcd <= bus.bcd_in;
                r_stg_dp  <= bus.dp_mask;
                r_stg_bl  <= bus.blink_mask;
            end

            // Boundary clear wins over a coincident load
            if (w_boundary)    r_busy <= 1'b0;
            else if (bus.load) r_busy <= 1'b1;

            if (w_boundary) begin
                r_shd_bcd <= w_shd_nxt_bcd;
                r_shd_dp  <= w_shd_nxt_dp;
                r_shd_bl  <= w_shd_nxt_bl;
                r_frm     <= w_frm_wrap ? '0 : r_frm + 1'b1;
                r_hidden  <= w_hidden_nxt;
            end

            if (w_tick) begin
                r_idx   <= (r_idx == C_IDX_LAST) ? '0 : r_idx + 1'b1;
                an      <= ~(DIGITS'(1) << r_idx);
                seg_out <= w_seg;
            end
        end
    end

    assign bus.busy       = r_busy;
    assign bus.frame_done = r_frame_done;

endmodule
`default_nettype wire
